// File: rtl/can_bit_destuffer.sv
// CAN bit destuffer.
// Receives one serial bit per sample-point strobe and removes stuff bits.
// Dynamic mode drops the complement bit inserted after STUFF_LEN equal bits.
// Fixed mode drops the complement bit inserted after every FIXED_LEN data bits.
// Valid data bits are announced with a one-clock sp_decision pulse, and stuff
// rule violations with a one-clock stuff_err pulse. In both cases the bit
// event happens on the first clock of each SP high phase.
module can_bit_destuffer #(
   parameter int STUFF_LEN = 5,
   parameter int FIXED_LEN = 4,
   parameter int SCNT_W    = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RX,
   input  logic              SP,
   input  logic              F_STF,
   input  logic              F_FIX,
   output logic              sp_decision,
   output logic              saida,
   output logic              stuff_err,
   output logic [SCNT_W-1:0] stuff_cnt
);

   // Counters are sized so they can hold their terminal value exactly.
   localparam int RUN_W  = (STUFF_LEN < 1) ? 1 : $clog2(STUFF_LEN + 1);
   localparam int FCNT_W = (FIXED_LEN < 1) ? 1 : $clog2(FIXED_LEN + 1);

   localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(STUFF_LEN);
   localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);
   localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FIXED_LEN);
   localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);
   localparam logic [SCNT_W-1:0] SCNT_ONE = SCNT_W'(1);

   // The mode that applies to the current bit event.
   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_DYN   = 2'd1,
      MODE_FIXED = 2'd2
   } mode_t;

   // Registered state.
   logic              r_spPrev;
   logic              r_lastb;
   logic [RUN_W-1:0]  r_run;
   logic [FCNT_W-1:0] r_fcnt;
   logic              r_fexp;
   logic              r_fixPrev;
   logic              r_fixFirst;
   logic [SCNT_W-1:0] r_cnt;
   logic              r_dec;
   logic              r_saida;
   logic              r_err;

   // Combinational next-state values.
   mode_t             w_mode;
   logic              w_event;
   logic              w_fixChg;
   logic [RUN_W-1:0]  w_runCur;
   logic [FCNT_W-1:0] w_fcntCur;
   logic              w_fexpCur;
   logic              w_fixFirstCur;
   logic [FCNT_W-1:0] w_fcntInc;
   logic              w_lastbNext;
   logic [RUN_W-1:0]  w_runNext;
   logic [FCNT_W-1:0] w_fcntNext;
   logic              w_fexpNext;
   logic              w_fixPrevNext;
   logic              w_fixFirstNext;
   logic [SCNT_W-1:0] w_cntNext;
   logic              w_decNext;
   logic              w_saidaNext;
   logic              w_errNext;

   // A bit event is the first clock of an SP high phase, so a strobe
   // held high over several clocks still counts as a single bit.
   assign w_event = SP & ~r_spPrev;

   // A mode change is noticed at the first event after it. That event
   // restarts the run and fixed-mode counters. When the change is a
   // rise into fixed mode, it also arms the "first bit is a stuff bit"
   // flag, which stays armed across pass-through events until a fixed
   // mode event with destuffing enabled consumes it.
   assign w_fixChg      = F_FIX ^ r_fixPrev;
   assign w_runCur      = w_fixChg ? '0 : r_run;
   assign w_fcntCur     = w_fixChg ? '0 : r_fcnt;
   assign w_fexpCur     = w_fixChg ? 1'b0 : r_fexp;
   assign w_fixFirstCur = F_FIX & (r_fixFirst | ~r_fixPrev);
   assign w_fcntInc     = w_fcntCur + FCNT_ONE;
   assign w_fixPrevNext = w_event ? F_FIX : r_fixPrev;

   // Select the mode. F_STF is taken from the event edge itself.
   always_comb begin
      w_mode = MODE_PASS;
      if (F_STF) begin
         w_mode = F_FIX ? MODE_FIXED : MODE_DYN;
      end
   end

   // Decide the fate of the current bit: deliver it, drop it as stuff,
   // or flag a stuff violation. State holds and pulses drop between events.
   always_comb begin
      w_lastbNext    = r_lastb;
      w_runNext      = r_run;
      w_fcntNext     = r_fcnt;
      w_fexpNext     = r_fexp;
      w_fixFirstNext = r_fixFirst;
      w_cntNext      = r_cnt;
      w_decNext      = 1'b0;
      w_saidaNext    = r_saida;
      w_errNext      = 1'b0;

      if (w_event) begin
         w_runNext      = w_runCur;
         w_fcntNext     = w_fcntCur;
         w_fexpNext     = w_fexpCur;
         w_fixFirstNext = w_fixFirstCur;

         unique case (w_mode)
            MODE_PASS: begin
               w_decNext   = 1'b1;
               w_saidaNext = RX;
               w_cntNext   = '0;
               w_runNext   = '0;
               w_fexpNext  = 1'b1;
            end

            MODE_DYN: begin
               if (w_runCur < RUN_MAX) begin
                  w_decNext   = 1'b1;
                  w_saidaNext = RX;
                  if ((RX == r_lastb) && (w_runCur != '0)) begin
                     w_runNext = w_runCur + RUN_ONE;
                  end else begin
                     w_runNext = RUN_ONE;
                  end
                  w_lastbNext = RX;
               end else if (RX != r_lastb) begin
                  w_cntNext   = r_cnt + SCNT_ONE;
                  w_runNext   = RUN_ONE;
                  w_lastbNext = RX;
               end else begin
                  w_errNext = 1'b1;
                  w_runNext = '0;
               end
            end

            MODE_FIXED: begin
               if (w_fixFirstCur) begin
                  w_fixFirstNext = 1'b0;
                  w_fexpNext     = 1'b0;
                  w_fcntNext     = '0;
                  w_lastbNext    = RX;
               end else if (!w_fexpCur) begin
                  w_decNext   = 1'b1;
                  w_saidaNext = RX;
                  w_fcntNext  = w_fcntInc;
                  w_fexpNext  = (w_fcntInc == FCNT_MAX);
                  w_lastbNext = RX;
               end else begin
                  w_errNext  = (RX == r_lastb);
                  w_fcntNext = '0;
                  w_fexpNext = 1'b0;
               end
            end

            default: begin
               w_decNext = 1'b0;
            end
         endcase
      end
   end

   // Register the state and the outputs. Asynchronous reset restores the
   // idle bus condition.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_spPrev   <= 1'b0;
         r_lastb    <= 1'b1;
         r_run      <= '0;
         r_fcnt     <= '0;
         r_fexp     <= 1'b1;
         r_fixPrev  <= 1'b0;
         r_fixFirst <= 1'b0;
         r_cnt      <= '0;
         r_dec      <= 1'b0;
         r_saida    <= 1'b1;
         r_err      <= 1'b0;
      end else begin
         r_spPrev   <= SP;
         r_lastb    <= w_lastbNext;
         r_run      <= w_runNext;
         r_fcnt     <= w_fcntNext;
         r_fexp     <= w_fexpNext;
         r_fixPrev  <= w_fixPrevNext;
         r_fixFirst <= w_fixFirstNext;
         r_cnt      <= w_cntNext;
         r_dec      <= w_decNext;
         r_saida    <= w_saidaNext;
         r_err      <= w_errNext;
      end
   end

   assign sp_decision = r_dec;
   assign saida       = r_saida;
   assign stuff_err   = r_err;
   assign stuff_cnt   = r_cnt;

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Self-checking bench for can_bit_destuffer using a reference model and a
// scoreboard of expected output pulses.
module tb_can_bit_destuffer;

   localparam int STUFF_LEN = 5;
   localparam int FIXED_LEN = 4;
   localparam int SCNT_W    = 3;

   logic              clk;
   logic              reset;
   logic              RX;
   logic              SP;
   logic              F_STF;
   logic              F_FIX;
   logic              sp_decision;
   logic              saida;
   logic              stuff_err;
   logic [SCNT_W-1:0] stuff_cnt;

   int testCount;
   int failCount;

   // Each scoreboard entry holds {sp_decision, stuff_err, saida}.
   logic [2:0] expQ[$];

   // Reference model state.
   logic mLast;
   int   mRun;
   int   mFcnt;
   logic mFexp;
   logic mFixPrev;
   logic mFixFirst;
   int   mCnt;
   logic mSaida;

   can_bit_destuffer #(
      .STUFF_LEN(STUFF_LEN),
      .FIXED_LEN(FIXED_LEN),
      .SCNT_W(SCNT_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .RX(RX),
      .SP(SP),
      .F_STF(F_STF),
      .F_FIX(F_FIX),
      .sp_decision(sp_decision),
      .saida(saida),
      .stuff_err(stuff_err),
      .stuff_cnt(stuff_cnt)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Return the model to its reset state.
   task automatic modelReset();
      mLast     = 1'b1;
      mRun      = 0;
      mFcnt     = 0;
      mFexp     = 1'b1;
      mFixPrev  = 1'b0;
      mFixFirst = 1'b0;
      mCnt      = 0;
      mSaida    = 1'b1;
      expQ.delete();
   endtask

   // Model one bit event, and queue any pulse it should produce.
   task automatic modelBit(input logic rx, input logic stf, input logic fix);
      if (fix != mFixPrev) begin
         mRun  = 0;
         mFcnt = 0;
         mFexp = 1'b0;
         if (fix) mFixFirst = 1'b1;
      end
      if (!fix) mFixFirst = 1'b0;
      mFixPrev = fix;

      if (!stf) begin
         expQ.push_back({1'b1, 1'b0, rx});
         mSaida = rx;
         mCnt   = 0;
         mRun   = 0;
         mFexp  = 1'b1;
      end else if (!fix) begin
         if (mRun < STUFF_LEN) begin
            expQ.push_back({1'b1, 1'b0, rx});
            mSaida = rx;
            mRun   = (rx == mLast && mRun > 0) ? mRun + 1 : 1;
            mLast  = rx;
         end else if (rx != mLast) begin
            mCnt  = (mCnt + 1) % (1 << SCNT_W);
            mRun  = 1;
            mLast = rx;
         end else begin
            expQ.push_back({1'b0, 1'b1, mSaida});
            mRun = 0;
         end
      end else begin
         if (mFixFirst) begin
            mFixFirst = 1'b0;
            mFexp     = 1'b0;
            mFcnt     = 0;
            mLast     = rx;
         end else if (!mFexp) begin
            expQ.push_back({1'b1, 1'b0, rx});
            mSaida = rx;
            mFcnt++;
            if (mFcnt == FIXED_LEN) mFexp = 1'b1;
            mLast = rx;
         end else begin
            if (rx == mLast) expQ.push_back({1'b0, 1'b1, mSaida});
            mFcnt = 0;
            mFexp = 1'b0;
         end
      end
   endtask

   // Drive one bit with SP held high for `hold` clocks, then check that the
   // scoreboard drained and that the counter and held data bit match.
   task automatic applyStimulus(input logic rx, input logic stf, input logic fix, input int hold);
      @(negedge clk);
      RX    = rx;
      F_STF = stf;
      F_FIX = fix;
      SP    = 1'b1;
      modelBit(rx, stf, fix);
      repeat (hold) @(negedge clk);
      SP = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("queue_drained", expQ.size(), 0);
      checkOutput("stuff_cnt", 32'(stuff_cnt), 32'(mCnt));
      checkOutput("saida_hold", 32'(saida), 32'(mSaida));
   endtask

   // Assert reset, check the reset values while it is held, then release it.
   task automatic applyReset();
      @(negedge clk);
      reset = 1'b1;
      SP    = 1'b0;
      #1;
      checkOutput("rst_sp_decision", 32'(sp_decision), 0);
      checkOutput("rst_saida", 32'(saida), 1);
      checkOutput("rst_stuff_err", 32'(stuff_err), 0);
      checkOutput("rst_stuff_cnt", 32'(stuff_cnt), 0);
      modelReset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Scoreboard consumer: every output pulse must match the next expected entry.
   always @(negedge clk) begin
      if (!reset && (sp_decision || stuff_err)) begin
         checkOutput("pulse_exclusive", 32'(sp_decision & stuff_err), 0);
         if (expQ.size() == 0) begin
            checkOutput("unexpected_pulse", {30'd0, sp_decision, stuff_err}, 0);
         end else begin
            logic [2:0] e;
            e = expQ.pop_front();
            checkOutput("sp_decision", 32'(sp_decision), 32'(e[2]));
            checkOutput("stuff_err", 32'(stuff_err), 32'(e[1]));
            if (e[2]) checkOutput("saida", 32'(saida), 32'(e[0]));
         end
      end
   end

   // Safety net so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "[TB] watchdog");
   end

   // Test sequence.
   initial begin
      logic [6:0] seqA;
      logic       v;
      logic       fx;
      testCount = 0;
      failCount = 0;
      RX    = 1'b1;
      SP    = 1'b0;
      F_STF = 1'b1;
      F_FIX = 1'b0;
      reset = 1'b0;
      modelReset();

      // Reset values, then five zeros, a stuff one and a zero data bit.
      applyReset();
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1);
      applyStimulus(1'b1, 1'b1, 1'b0, 2);
      checkOutput("cnt_after_stuff", 32'(stuff_cnt), 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1);

      // Six ones trigger a stuff error on the sixth bit.
      applyReset();
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1);
      checkOutput("cnt_after_err", 32'(stuff_cnt), 0);

      // Build a count, then pass-through mode clears it and passes every bit.
      applyReset();
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1);
      checkOutput("cnt_passthru", 32'(stuff_cnt), 0);

      // Fixed mode, valid frame; the count built beforehand stays frozen.
      applyReset();
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1);
      seqA = 7'b1001101;
      for (int i = 6; i >= 0; i--) applyStimulus(seqA[i], 1'b1, 1'b1, 1);
      checkOutput("cnt_frozen_fixed", 32'(stuff_cnt), 1);

      // Fixed mode, sixth bit breaks the fixed stuff rule.
      applyReset();
      seqA = 7'b1001111;
      for (int i = 6; i >= 0; i--) applyStimulus(seqA[i], 1'b1, 1'b1, 1);

      // Nine dynamic stuff bits wrap the 3-bit counter; SP held three clocks.
      applyReset();
      v = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus(v, 1'b1, 1'b0, 3);
      for (int s = 0; s < 9; s++) begin
         v = ~v;
         for (int i = 0; i < 5; i++) applyStimulus(v, 1'b1, 1'b0, 3);
      end
      checkOutput("cnt_wrap", 32'(stuff_cnt), 1);

      // Reset in the middle of a run discards it.
      applyReset();
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1);
      applyReset();
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1);
      checkOutput("cnt_after_rst_run", 32'(stuff_cnt), 1);

      // Random traffic with occasional mode changes and pass-through bits.
      applyReset();
      fx = 1'b0;
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 19) == 0) fx = ~fx;
         applyStimulus(($urandom_range(0, 3) == 0) ? ~mLast : mLast,
                       ($urandom_range(0, 9) != 0), fx, $urandom_range(1, 3));
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/can_bit_destuffer.md
CAN_BIT_DESTUFFER -- requirements
Module: can_bit_destuffer

Interface
REQ-001 SHALL have parameter STUFF_LEN, default 5, giving the run of equal bits after which a dynamic stuff bit is expected.
REQ-002 SHALL have parameter FIXED_LEN, default 4, giving the data bits between fixed stuff bits in fixed mode.
REQ-003 SHALL have parameter SCNT_W, default 3, giving the width of the dynamic stuff-bit counter.
REQ-004 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port RX  input  1  the serial bus bit, valid at the sample point.
REQ-007 SHALL have port SP  input  1  the sample-point strobe, which may stay high for several clocks.
REQ-008 SHALL have port F_STF  input  1  the destuffing enable; when 0, every bit passes through.
REQ-009 SHALL have port F_FIX  input  1  the mode select: 0 = dynamic stuffing, 1 = fixed stuffing.
REQ-010 SHALL have port sp_decision  output  1  a one-cycle pulse marking a valid destuffed data bit.
REQ-011 SHALL have port saida  output  1  the destuffed data bit, valid while sp_decision=1.
REQ-012 SHALL have port stuff_err  output  1  a one-cycle pulse marking a stuff rule violation.
REQ-013 SHALL have port stuff_cnt  output  SCNT_W  the count, modulo 2^SCNT_W, of dynamic stuff bits removed.

Function
REQ-014 SHALL define a bit event as a rising clk edge where SP=1 and the registered previous SP=0; SP held high over N clocks yields exactly one event.
REQ-015 SHALL register all outputs on the event edge; sp_decision and stuff_err SHALL be high for exactly the one following clock.
REQ-016 SHALL hold saida at its last value between events.
REQ-017 SHALL keep internal state: last bit (lastb), run length (run), fixed-mode data counter (fcnt), and the fixed-stuff-expected flag (fexp).
REQ-018 With F_STF=0 at an event, SHALL pulse sp_decision, set saida=RX, assert no stuff_err, clear stuff_cnt, set run=0, and set fexp=1.
REQ-019 In dynamic mode (F_STF=1, F_FIX=0) with run<STUFF_LEN at an event, SHALL pulse sp_decision and set saida=RX.
REQ-020 In the REQ-019 case, SHALL increment run if RX==lastb and run>0, else set run=1; lastb SHALL become RX.
REQ-021 In dynamic mode with run==STUFF_LEN and RX!=lastb, SHALL treat the bit as stuff: no sp_decision, stuff_cnt+1 wrapping from 2^SCNT_W-1 to 0, run=1, lastb=RX.
REQ-022 In dynamic mode with run==STUFF_LEN and RX==lastb, SHALL pulse stuff_err with no sp_decision, set run=0, and leave stuff_cnt unchanged.
REQ-023 In fixed mode (F_STF=1, F_FIX=1), the first event after F_FIX rises SHALL be a stuff bit that is accepted without check; it sets fexp=0, fcnt=0, and lastb=RX.
REQ-024 In fixed mode with fexp=0, SHALL pulse sp_decision with saida=RX and increment fcnt; when fcnt reaches FIXED_LEN, SHALL set fexp=1; lastb SHALL become RX.
REQ-025 In fixed mode with fexp=1, SHALL require RX==~lastb; on a match, no output and fcnt=0, fexp=0; on a mismatch, pulse stuff_err, then fcnt=0, fexp=0.
REQ-026 SHALL freeze stuff_cnt in fixed mode and hold it until F_STF=0 or reset.
REQ-027 SHALL take an F_FIX change into account at the first event after the change, and SHALL clear run, fcnt and fexp on that change.
REQ-028 An F_STF change SHALL apply to the event of the same edge, with inputs sampled at that edge.
REQ-029 SHALL never assert sp_decision and stuff_err in the same cycle.

Reset
REQ-030 While reset=1, SHALL force sp_decision=0, saida=1, stuff_err=0, stuff_cnt=0, lastb=1, run=0, fcnt=0, fexp=1, and the registered SP=0.
REQ-031 SHALL take the first bit event on the first SP rising edge after reset is released, and SHALL discard any partial run.

Verification
REQ-032 With STUFF_LEN=5, F_STF=1, F_FIX=0, RX=0,0,0,0,0,1,0 -> five pulses with saida=0, none on the 6th bit, stuff_cnt=1, and a pulse with saida=0 on the 7th.
REQ-033 With dynamic mode and RX=1 for six events -> five pulses, then stuff_err on the 6th with no sp_decision and stuff_cnt=0.
REQ-034 With F_STF=0 and RX=0 for eight events -> eight sp_decision pulses, no stuff_err, stuff_cnt=0.
REQ-035 With F_FIX=1 and FIXED_LEN=4, RX=1(stuff),0,0,1,1,0(stuff),1 -> pulses on bits 2-5 and 7 only, no error; the same sequence with the 6th bit=1 -> stuff_err on the 6th.
REQ-036 With SCNT_W=3 and nine dynamic stuff bits (alternating runs of five) -> stuff_cnt reads 1 at the end (7->0 wrap); SP held high for 3 clocks -> exactly one event.
REQ-037 Reset asserted after three equal bits, then released, then RX=0 x5 and 1 -> outputs return to the REQ-030 values during reset, and the 6th bit after release is removed as stuff.
